bandpass_fir: RTL and testbench
===============================

// Module: bandpass_fir
// PURPOSE
//  31-tap symmetric linear-phase band-pass FIR, passband ~fs/8..3fs/8 (centre fs/4).
//  Streaming: one signed sample in per valid_in, one filtered sample out per accepted input.
//  Sits in the sample-rate DSP chain between an input stage and downstream gain/decimation.
// PARAMETERS
//  DATA_W   16  input sample width, signed two's complement
//  TAP_CNT  31  number of taps; only 31 is supported (elaboration error otherwise)
//  GAIN_W    4  extra output headroom bits; data_out width = DATA_W+GAIN_W
// PORTS
//  clk        in   1                system clock, rising edge
//  rst        in   1                asynchronous, active-low reset
//  valid_in   in   1                data_in valid this cycle
//  data_in    in   DATA_W           signed input sample
//  valid_out  out  1                data_out valid this cycle (1-cycle pulse per sample)
//  data_out   out  DATA_W+GAIN_W    signed filtered sample
// BEHAVIOUR
//  - Coefficients Q1.15 (COEF_W=16, COEF_FRAC=15), c[n]=c[30-n]:
//    c[15]=16384; c[13]=c[17]=-10014; c[9]=c[21]=2371; c[5]=c[25]=-647;
//    c[1]=c[29]=134; all other taps 0. DC gain 72/32768, fs/4 gain 32696/32768.
//  - y[n] = sum_k c[k]*x[n-k], full precision (>=37b signed); data_out = acc>>>15
//    (arithmetic, floor), saturated to signed DATA_W+GAIN_W range.
//  - Delay line shifts only when valid_in=1; valid_in=0 holds history (gaps do not
//    insert zeros). Output for sample n is independent of gap pattern.
//  - Latency 3 clocks: sample taken at edge N -> valid_out=1 with its result after edge N+3.
//    Stage1 delay-line shift; stage2 symmetric pre-add + constant multiply; stage3 adder
//    tree, shift, saturate into output register.
//  - valid_out follows valid_in through a 3-deep valid pipe; back-to-back inputs give
//    back-to-back outputs; no backpressure, input always accepted.
//  - data_out holds last value while valid_out=0.
//  - Reset (rst=0, async): delay line, pipeline regs, valid pipe, valid_out, data_out -> 0.
//    Mid-stream reset discards in-flight results; history restarts from zeros.
//  - First 30 outputs after reset are transient (zero-prefilled history).
// STRUCTURE
//  - Package bandpass_fir_pkg: COEF_W, COEF_FRAC, coefficient array (31 x signed 16b),
//    LATENCY=3.
//  - One sub-module: fir_adder_tree (parameterised signed pipelined sum of 16 products).
//  - Top holds delay line, pre-adders, constant multipliers, valid pipe, saturation.
// TESTING
//  1 Reset: hold rst=0 with valid_in=1 toggling -> valid_out=0, data_out=0 throughout.
//  2 Impulse 1000 then zeros, valid_in=1 continuous -> first output 3 clk after impulse;
//    sequence idx1=4, idx5=-20, idx9=72, idx13=-306, idx15=500, idx17=-306, idx21=72,
//    idx25=-20, idx29=4, all other idx 0.
//  3 DC: constant 10000 for 40 samples -> settles to 21; constant -32768 -> settles to -72.
//  4 fs/4 tone 0,16384,0,-16384,... -> steady outputs cycle through 16348,0,-16348,0.
//  5 Impulse test with valid_in=0 for 5 cycles between every sample -> identical value
//    sequence as test 2; valid_out count equals accepted-input count.
//  6 Reset asserted mid-stream (after 10 samples) -> outputs 0 immediately, no stale
//    valid_out; restart with impulse reproduces test 2 exactly.

Source files
------------

// File: rtl/bandpass_fir_pkg.sv
// Shared constants for the 31-tap band-pass FIR: coefficient format,
// the Q1.15 coefficient table (symmetric, c[n] == c[30-n]) and pipeline latency.
package bandpass_fir_pkg;

  localparam int unsigned COEF_W    = 16;
  localparam int unsigned COEF_FRAC = 15;
  localparam int unsigned COEF_CNT  = 31;
  localparam int unsigned LATENCY   = 3;

  // Band-pass centred on fs/4; only odd taps plus the centre are non-zero.
  localparam logic signed [COEF_W-1:0] COEFS [COEF_CNT] = '{
    16'sd0,      16'sd134,   16'sd0,     16'sd0,     16'sd0,
    -16'sd647,   16'sd0,     16'sd0,     16'sd0,     16'sd2371,
    16'sd0,      16'sd0,     16'sd0,     -16'sd10014, 16'sd0,
    16'sd16384,
    16'sd0,      -16'sd10014, 16'sd0,    16'sd0,     16'sd0,
    16'sd2371,   16'sd0,     16'sd0,     16'sd0,     -16'sd647,
    16'sd0,      16'sd0,     16'sd0,     16'sd134,   16'sd0
  };

endpackage

// File: rtl/fir_adder_tree.sv
// Signed sum of N products with one output register stage.
// Ports:
//   clk, rst   clock / async active-low reset
//   terms      N signed IN_W-bit products
//   sum        registered signed OUT_W-bit total
module fir_adder_tree
  import bandpass_fir_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned IN_W  = 33,
  parameter int unsigned OUT_W = 37
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  terms [N],
  output logic signed [OUT_W-1:0] sum
);

  logic signed [OUT_W-1:0] sum_c;

  // OUT_W carries log2(N) growth bits, so the total never wraps.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) begin
      sum_c = sum_c + OUT_W'(terms[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
    end else begin
      sum <= sum_c;
    end
  end

endmodule

// File: rtl/bandpass_fir.sv
// 31-tap symmetric linear-phase band-pass FIR (passband ~fs/8..3fs/8).
// One signed sample in per valid_in, one filtered sample out three clocks later.
// Ports:
//   clk, rst    clock / async active-low reset
//   valid_in    data_in valid this cycle (always accepted)
//   data_in     signed DATA_W-bit sample
//   valid_out   one-cycle pulse per result
//   data_out    signed DATA_W+GAIN_W-bit result, held between pulses
module bandpass_fir
  import bandpass_fir_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TAP_CNT = 31,
  parameter int unsigned GAIN_W  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  input  logic signed [DATA_W-1:0]        data_in,
  output logic                            valid_out,
  output logic signed [DATA_W+GAIN_W-1:0] data_out
);

  localparam int unsigned HALF   = TAP_CNT / 2;
  localparam int unsigned NPROD  = HALF + 1;
  localparam int unsigned PRE_W  = DATA_W + 1;
  localparam int unsigned PROD_W = PRE_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(NPROD);
  localparam int unsigned OUT_W  = DATA_W + GAIN_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (TAP_CNT != COEF_CNT) begin : g_tap_check
    $error("bandpass_fir: only TAP_CNT=31 is supported");
  end

  logic signed [DATA_W-1:0] taps [TAP_CNT];
  logic signed [PRE_W-1:0]  pre_c [NPROD];
  logic signed [PROD_W-1:0] prod [NPROD];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted_c;
  logic signed [OUT_W-1:0]  sat_c;
  logic [LATENCY-1:0]       vpipe;

  // Stage 1: delay line advances only on accepted samples; gaps keep history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAP_CNT; i++) begin
        taps[i] <= '0;
      end
    end else if (valid_in) begin
      taps[0] <= data_in;
      for (int i = 1; i < TAP_CNT; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  // Symmetric pre-add halves the multiplier count; centre tap passes alone.
  always_comb begin
    for (int k = 0; k < HALF; k++) begin
      pre_c[k] = PRE_W'(taps[k]) + PRE_W'(taps[TAP_CNT-1-k]);
    end
    pre_c[HALF] = PRE_W'(taps[HALF]);
  end

  // Stage 2: constant multiplies (zero taps fold away in synthesis).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPROD; k++) begin
        prod[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NPROD; k++) begin
        prod[k] <= PROD_W'(pre_c[k]) * PROD_W'(COEFS[k]);
      end
    end
  end

  // Stage 3a: registered sum of all products.
  fir_adder_tree #(
    .N     (NPROD),
    .IN_W  (PROD_W),
    .OUT_W (ACC_W)
  ) u_tree (
    .clk   (clk),
    .rst   (rst),
    .terms (prod),
    .sum   (acc)
  );

  // Drop the Q1.15 fraction (floor) and clamp to the output range.
  always_comb begin
    shifted_c = acc >>> COEF_FRAC;
    if (shifted_c > SAT_MAX) begin
      sat_c = SAT_MAX[OUT_W-1:0];
    end else if (shifted_c < SAT_MIN) begin
      sat_c = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_c = shifted_c[OUT_W-1:0];
    end
  end

  // Stage 3b: valid pipe tracks the data stages; output register holds between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe     <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      vpipe     <= {vpipe[LATENCY-2:0], valid_in};
      valid_out <= vpipe[LATENCY-1];
      if (vpipe[LATENCY-1]) begin
        data_out <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_bandpass_fir.sv
// Self-checking bench for bandpass_fir: direct-form reference model with
// cycle-stamped expectations, plus literal expectations for impulse, DC and fs/4.
module tb_bandpass_fir;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned GAIN_W = 4;
  localparam int unsigned OUT_W  = DATA_W + GAIN_W;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    valid_in = 1'b0;
  logic signed [DATA_W-1:0] data_in = '0;
  logic                    valid_out;
  logic signed [OUT_W-1:0] data_out;

  bandpass_fir #(
    .DATA_W  (DATA_W),
    .TAP_CNT (31),
    .GAIN_W  (GAIN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t   exp_q[$];
  int     cap[$];
  longint hist[31];
  int     cyc = 0;
  int     last_out = 0;
  int     accepted = 0;
  int     checks = 0;
  int     errors = 0;

  function automatic void check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endfunction

  function automatic int coef(int k);
    case (k)
      15:      return 16384;
      13, 17:  return -10014;
      9, 21:   return 2371;
      5, 25:   return -647;
      1, 29:   return 134;
      default: return 0;
    endcase
  endfunction

  function automatic int imp_exp(int i);
    case (i)
      1, 29:   return 4;
      5, 25:   return -20;
      9, 21:   return 72;
      13, 17:  return -306;
      15:      return 500;
      default: return 0;
    endcase
  endfunction

  function automatic void clear_model();
    for (int k = 0; k < 31; k++) hist[k] = 0;
    exp_q.delete();
    cap.delete();
    last_out = 0;
  endfunction

  // Reference: y[n] = floor(sum c[k]*x[n-k] / 2^15), saturated; due 3 edges after acceptance.
  always @(posedge clk) begin
    longint acc;
    longint y;
    cyc = cyc + 1;
    if (rst === 1'b1 && valid_in === 1'b1) begin
      for (int k = 30; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = longint'(data_in);
      acc = 0;
      for (int k = 0; k < 31; k++) acc += longint'(coef(k)) * hist[k];
      y = acc >>> 15;
      if (y > 524287) y = 524287;
      if (y < -524288) y = -524288;
      exp_q.push_back('{int'(y), cyc + 3});
      accepted++;
    end
  end

  // Compare DUT against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      check("reset_valid", int'(valid_out), 0);
      check("reset_data", int'(data_out), 0);
    end else if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("latency", cyc, e.due);
        check("data", int'(data_out), e.val);
        last_out = e.val;
        cap.push_back(int'(data_out));
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("missing_valid", 0, 1);
        void'(exp_q.pop_front());
      end
      check("hold", int'(data_out), last_out);
    end
  end

  task automatic send(input int x, input int gap);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = 16'(x);
    repeat (gap) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    valid_in = 1'b0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Assert reset mid-cycle, confirm outputs clear at once, release on a falling edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst      = 1'b0;
    valid_in = 1'b0;
    clear_model();
    #1;
    check("reset_now_valid", int'(valid_out), 0);
    check("reset_now_data", int'(data_out), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic impulse_run(input int gap, input string tag);
    int acc0;
    acc0 = accepted;
    cap.delete();
    send(1000, gap);
    repeat (30) send(0, gap);
    drain();
    check({tag, "_count"}, cap.size(), accepted - acc0);
    if (cap.size() < 31) begin
      check({tag, "_short"}, cap.size(), 31);
    end else begin
      for (int i = 0; i < 31; i++) begin
        check($sformatf("%s_idx%0d", tag, i), cap[i], imp_exp(i));
      end
    end
  endtask

  initial begin
    clear_model();
    #1 rst = 1'b0;

    // Reset held while valid_in toggles: outputs must stay zero.
    repeat (8) begin
      @(negedge clk);
      valid_in = ~valid_in;
      data_in  = 16'(1234);
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b1;

    impulse_run(0, "impulse");

    // DC response.
    do_reset();
    repeat (40) send(10000, 0);
    drain();
    if (cap.size() >= 40) check("dc_pos", cap[39], 21);
    else check("dc_pos_short", cap.size(), 40);
    repeat (40) send(-32768, 0);
    drain();
    if (cap.size() >= 80) check("dc_neg", cap[79], -72);
    else check("dc_neg_short", cap.size(), 80);

    // fs/4 tone at the passband centre.
    do_reset();
    repeat (10) begin
      send(0, 0);
      send(16384, 0);
      send(0, 0);
      send(-16384, 0);
    end
    drain();
    if (cap.size() >= 40) begin
      check("tone_36", cap[36], 16348);
      check("tone_37", cap[37], 0);
      check("tone_38", cap[38], -16348);
      check("tone_39", cap[39], 0);
    end else begin
      check("tone_short", cap.size(), 40);
    end

    // Gaps between samples must not change the value sequence.
    do_reset();
    impulse_run(5, "gapped");

    // Mid-stream reset with results in flight, then a clean restart.
    do_reset();
    for (int i = 0; i < 10; i++) send(i * 1500 - 4000, 0);
    do_reset();
    impulse_run(0, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
